// File: rtl/spi_slave_if_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slave_if_if
// Command/response bus between the SPI slave front end and the RAM.
//   rx_data  [MEM_WIDTH+1:0] : command word, bits [MEM_WIDTH+1:MEM_WIDTH] are
//                              the control field (00 WR_ADDR, 01 WR_DATA,
//                              10 RD_ADDR, 11 RD_DATA)
//   rx_valid                 : one-cycle strobe, rx_data is valid
//   tx_data  [MEM_WIDTH-1:0] : RAM read data
//   tx_valid                 : one-cycle strobe, tx_data is valid
// Modports:
//   master : the SPI front end (issues commands, receives read data)
//   slave  : the RAM (consumes commands, returns read data)
// -----------------------------------------------------------------------------
interface spi_slave_if_if #(
  parameter int MEM_WIDTH = 8
);
  logic [MEM_WIDTH+1:0] rx_data;
  logic                 rx_valid;
  logic [MEM_WIDTH-1:0] tx_data;
  logic                 tx_valid;

  modport master (
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slave_if
// Serial-to-parallel front end of the SPI RAM system. Deserialises
// (MEM_WIDTH+2)-bit command words from MOSI and hands them to the RAM as
// rx_data/rx_valid. For read-data commands it takes the RAM's tx_data/tx_valid
// response and shifts it out MSB-first on MISO. Everything is sampled and
// driven on the rising edge of clk.
//
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   SS_n       : slave select, active-low; a frame is the interval SS_n=0
//   MOSI       : serial data from master, MSB first
//   MISO       : serial read data to master
//   frame_err  : one-cycle pulse on an aborted frame
//                (only when SPI_SLAVE_FRAME_ERR_EN is defined)
//   ram        : spi_slave_if_if.master (rx_data, rx_valid, tx_data, tx_valid)
//
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN
// -----------------------------------------------------------------------------
module spi_slave_if #(
  parameter int MEM_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
`ifdef SPI_SLAVE_FRAME_ERR_EN
  output logic            frame_err,
`endif
  spi_slave_if_if.master  ram
);

  localparam int CW    = MEM_WIDTH + 2;
  localparam int CNT_W = $clog2(CW + 1);
  localparam int TXC_W = (MEM_WIDTH > 1) ? $clog2(MEM_WIDTH) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CW - 1);
  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(CW);
  localparam logic [TXC_W-1:0] TX_LAST   = TXC_W'(MEM_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t               state;
  logic [CW-2:0]        shift_q;       // first CW-1 bits; the last bit comes straight from MOSI
  logic [CNT_W-1:0]     bit_cnt;       // data bits received in this frame
  logic                 rd_addr_received;
  logic                 rd_wait;       // READ_DATA word delivered, waiting for tx_valid
  logic                 tx_active;     // read-out in progress
  logic [TXC_W-1:0]     tx_cnt;        // bits still to drive after the current one
  logic [MEM_WIDTH-2:0] tx_rest;       // read-out bits below the one on MISO

  logic in_word;
  logic word_done;
  logic shift_en;
  logic tx_accept;

  always_comb begin
    in_word   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    word_done = (bit_cnt == WORD_BITS);
    shift_en  = in_word && !SS_n && !word_done;
    // rd_wait is set at the edge that raises rx_valid, so a tx_valid sampled
    // during the rx_valid cycle already falls inside the window.
    tx_accept = (state == READ_DATA) && !SS_n && rd_wait && ram.tx_valid;
  end

  // Data shift registers: carry no control meaning, so they are not reset.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      shift_q <= {shift_q[CW-3:0], MOSI};
    end
    if (tx_accept) begin
      tx_rest <= ram.tx_data[MEM_WIDTH-2:0];
    end else if (tx_active) begin
      tx_rest <= {tx_rest[MEM_WIDTH-3:0], 1'b0};
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      MISO             <= 1'b0;
      ram.rx_data      <= '0;
      ram.rx_valid     <= 1'b0;
      rd_addr_received <= 1'b0;
      bit_cnt          <= '0;
      rd_wait          <= 1'b0;
      tx_active        <= 1'b0;
      tx_cnt           <= '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err        <= 1'b0;
`endif
    end else begin
      ram.rx_valid <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err    <= 1'b0;
`endif
      if ((state != IDLE) && SS_n) begin
        // Frame ended by the master: drop any partial word or read-out.
        state     <= IDLE;
        bit_cnt   <= '0;
        MISO      <= 1'b0;
        rd_wait   <= 1'b0;
        tx_active <= 1'b0;
        tx_cnt    <= '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        // Abort = word incomplete, or read-out not yet at bit 0. A frame that
        // never got past CHK_CMD is not counted.
        frame_err <= (in_word && !word_done) || rd_wait ||
                     (tx_active && (tx_cnt != '0));
`endif
      end else begin
        case (state)
          IDLE: begin
            if (!SS_n) begin
              state <= CHK_CMD;
            end
          end

          CHK_CMD: begin
            bit_cnt <= '0;
            if (!MOSI) begin
              state <= WRITE;
            end else if (rd_addr_received) begin
              state <= READ_DATA;
            end else begin
              state <= READ_ADD;
            end
          end

          WRITE, READ_ADD, READ_DATA: begin
            if (shift_en) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                ram.rx_data  <= {shift_q, MOSI};
                ram.rx_valid <= 1'b1;
                if (state == READ_ADD) begin
                  rd_addr_received <= 1'b1;
                end
                if (state == READ_DATA) begin
                  rd_addr_received <= 1'b0;
                  rd_wait          <= 1'b1;
                end
              end
            end

            if (tx_accept) begin
              MISO      <= ram.tx_data[MEM_WIDTH-1];
              rd_wait   <= 1'b0;
              tx_active <= 1'b1;
              tx_cnt    <= TX_LAST;
            end else if (tx_active) begin
              if (tx_cnt != '0) begin
                MISO   <= tx_rest[MEM_WIDTH-2];
                tx_cnt <= tx_cnt - 1'b1;
              end else begin
                MISO      <= 1'b0;
                tx_active <= 1'b0;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
`timescale 1ns/1ps
// Testbench for spi_slave_if: directed SPI frames, rx scoreboard, MISO checks.
module tb_spi_slave_if;

  localparam int MW = 8;
  localparam int CW = MW + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic SS_n  = 1'b1;
  logic MOSI  = 1'b0;
  logic MISO;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err;
`endif

  spi_slave_if_if #(.MEM_WIDTH(MW)) bus ();

  spi_slave_if #(.MEM_WIDTH(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
`ifdef SPI_SLAVE_FRAME_ERR_EN
    .frame_err (frame_err),
`endif
    .ram       (bus)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CW-1:0] data;
    int            stamp;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];

  int n_tests   = 0;
  int n_fail    = 0;
  int mon_tests = 0;
  int mon_fail  = 0;

  // Monitor: every rx_valid must match the head of the expectation queue,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid) begin
      mon_tests++;
      if (exp_q.size() == 0) begin
        mon_fail++;
        $display("FAIL rx_unexpected: rx_valid=1 rx_data=%h at cyc %0d, none required", bus.rx_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.rx_data !== e.data || cyc != e.stamp) begin
          mon_fail++;
          $display("FAIL rx_word: got %h at cyc %0d, required %h at cyc %0d", bus.rx_data, cyc, e.data, e.stamp);
        end
      end
    end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (rst_n) begin
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        mon_tests++;
        void'(err_q.pop_front());
        if (frame_err !== 1'b1) begin
          mon_fail++;
          $display("FAIL frame_err_pulse: got %b at cyc %0d, required 1", frame_err, cyc);
        end
      end else if (frame_err !== 1'b0) begin
        mon_tests++;
        mon_fail++;
        $display("FAIL frame_err_spurious: got %b at cyc %0d, required 0", frame_err, cyc);
      end
    end
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives SS_n low, a junk bit in the IDLE->CHK_CMD cycle, the routing bit,
  // then nbits word bits MSB first. SS_n stays low on return.
  task automatic send_frame(input logic route, input logic [CW-1:0] word,
                            input int nbits, input bit expect_rx);
    int n;
    @(posedge clk); #1;
    SS_n = 1'b0;
    MOSI = 1'b1;
    n = cyc + 1;
    if (expect_rx) exp_q.push_back('{word, n + 11});
    @(posedge clk); #1;
    MOSI = route;
    for (int i = CW - 1; i >= CW - nbits; i--) begin
      @(posedge clk); #1;
      MOSI = word[i];
    end
  endtask

  // Lets the next edge sample the last driven bit, then raises SS_n.
  task automatic end_frame(input bit err);
    @(posedge clk); #1;
    SS_n = 1'b1;
    MOSI = 1'b0;
    if (err) err_q.push_back(cyc + 1);
  endtask

  // Presents tx_valid during the rx_valid cycle, then checks nchk MISO bits.
  task automatic read_out(input logic [MW-1:0] d, input int nchk);
    @(posedge clk); #1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    for (int k = 0; k < nchk; k++) begin
      @(negedge clk);
      chk($sformatf("miso_bit%0d", MW - 1 - k), {31'b0, MISO}, {31'b0, d[MW-1-k]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_miso",     {31'b0, MISO},                 32'h0);
    chk("rst_rx_valid", {31'b0, bus.rx_valid},         32'h0);
    chk("rst_rx_data",  {22'b0, bus.rx_data},          32'h0);
    chk("rst_rd_addr",  {31'b0, dut.rd_addr_received}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write address
    send_frame(1'b0, 10'h0A5, CW, 1'b1);
    end_frame(1'b0);
    repeat (3) @(negedge clk);
    chk("wr_addr_rd_flag", {31'b0, dut.rd_addr_received}, 32'h0);
    chk("wr_addr_hold",    {22'b0, bus.rx_data},          32'h0A5);

    // Write data, with a stray tx_valid that must not reach MISO
    send_frame(1'b0, 10'h13C, CW, 1'b1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    end_frame(1'b0);
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    @(negedge clk);
    chk("stray_tx_miso0", {31'b0, MISO}, 32'h0);
    @(negedge clk);
    chk("stray_tx_miso1", {31'b0, MISO}, 32'h0);

    // Read sequence
    send_frame(1'b1, 10'h2A5, CW, 1'b1);
    end_frame(1'b0);
    @(negedge clk);
    chk("rd_addr_set", {31'b0, dut.rd_addr_received}, 32'h1);
    send_frame(1'b1, 10'h300, CW, 1'b1);
    read_out(8'hC3, MW);
    end_frame(1'b0);
    @(negedge clk);
    chk("miso_after_read", {31'b0, MISO},                 32'h0);
    chk("rd_addr_clear",   {31'b0, dut.rd_addr_received}, 32'h0);

    // Abort after 5 data bits
    send_frame(1'b0, 10'h3FF, 5, 1'b0);
    end_frame(1'b1);
    repeat (2) @(negedge clk);
    chk("abort_rx_data", {22'b0, bus.rx_data}, 32'h300);

    // Aborted RD_ADDR followed at once by a new frame
    send_frame(1'b1, 10'h2FF, 3, 1'b0);
    end_frame(1'b1);
    send_frame(1'b0, 10'h055, CW, 1'b1);
    end_frame(1'b0);
    @(negedge clk);
    chk("abort_rd_flag", {31'b0, dut.rd_addr_received}, 32'h0);

    // Back-to-back WR_DATA frames with one idle cycle between
    send_frame(1'b0, 10'h111, CW, 1'b1);
    end_frame(1'b0);
    send_frame(1'b0, 10'h122, CW, 1'b1);
    end_frame(1'b0);

    // Async reset in the middle of a read-out
    send_frame(1'b1, 10'h2A5, CW, 1'b1);
    end_frame(1'b0);
    send_frame(1'b1, 10'h300, CW, 1'b1);
    read_out(8'hB2, 5);
    #2;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    #1;
    chk("arst_miso",     {31'b0, MISO},                 32'h0);
    chk("arst_rx_valid", {31'b0, bus.rx_valid},         32'h0);
    chk("arst_rx_data",  {22'b0, bus.rx_data},          32'h0);
    chk("arst_rd_flag",  {31'b0, dut.rd_addr_received}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(1'b0, 10'h0A5, CW, 1'b1);
    end_frame(1'b0);

    repeat (4) @(negedge clk);
    chk("rx_queue_drained", exp_q.size(), 32'h0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("err_queue_drained", err_q.size(), 32'h0);
`else
    err_q.delete();
`endif

    n_tests += mon_tests;
    n_fail  += mon_fail;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
